cdc_req_arbiter: RTL and testbench

CDC_REQ_ARBITER -- requirements
Module: cdc_req_arbiter

---
 rtl/cdc_pkg.sv | 28 ++
 rtl/cdc_rr_pick.sv | 45 ++++
 rtl/cdc_req_arbiter.sv | 137 +++++++++++++
 tb/tb_cdc_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// ============================================================================
// Module   : cdc_pkg
// Brief    : Shared state encodings and a constant clog2 helper for the
//            cdc request arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cdc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_rr_pick.sv
// ============================================================================
// Module   : cdc_rr_pick
// Brief    : Combinational round-robin picker: first set request at or after
//            ptr, wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdc_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;

    // Rotating the doubled vector puts the pointer position at bit 0
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        int s;
        valid = 1'b0;
        idx   = '0;
        s     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                s = int'(ptr) + k;
                if (s >= NREQ) begin
                    s = s - NREQ;
                end
                valid = 1'b1;
                idx   = IDXW'(s);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdc_req_arbiter.sv
// ============================================================================
// Module   : cdc_req_arbiter
// Brief    : Round-robin sharing of one handshake channel among NREQ
//            requesters, one transfer outstanding. Optional ack timeout is
//            enabled with the CDC_ARB_TIMEOUT_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdc_req_arbiter
    import cdc_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int TMO   = 255,
    localparam int IDXW  = clog2(NREQ)
) (
    input  logic                  rst,
    input  logic                  src_clk,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic                  busy,
    output logic [IDXW+WIDTH-1:0] hs_src,
    output logic                  hs_val,
    input  logic                  hs_ack
);

    arb_state_t        r_state;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_data;
    logic              r_hs_val;
    logic              r_busy;
    logic [NREQ-1:0]   r_done;
    logic              w_valid;
    logic [IDXW-1:0]   w_idx;
    logic [IDXW-1:0]   w_ptr_next;
    logic [NREQ-1:0]   w_idx_onehot;

    cdc_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_ptr_next   = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_idx_onehot = NREQ'(1) << r_idx;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNTW = clog2(TMO + 1);

    logic [CNTW-1:0] r_cnt;
    logic [NREQ-1:0] r_err;
`endif

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_hs_val <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= '0;
`endif
        end else begin
            r_hs_val <= 1'b0;
            r_done   <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            r_err    <= '0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_idx    <= w_idx;
                        r_data   <= req_data[int'(w_idx)*WIDTH +: WIDTH];
                        r_hs_val <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ARB_LAUNCH;
                    end
                end
                ARB_LAUNCH: begin
                    // An ack arriving here is early and deliberately dropped
                    r_state <= ARB_WAIT;
`ifdef CDC_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                ARB_WAIT: begin
                    if (hs_ack) begin
                        r_done  <= w_idx_onehot;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end
`ifdef CDC_ARB_TIMEOUT_EN
                    else if (r_cnt == CNTW'(TMO - 1)) begin
                        r_err   <= w_idx_onehot;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign hs_src = {r_idx, r_data};
    assign hs_val = r_hs_val;
    assign busy   = r_busy;
    assign done   = r_done;

`ifdef CDC_ARB_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdc_req_arbiter.sv
// ============================================================================
// Module   : tb_cdc_req_arbiter
// Brief    : Self-checking bench for cdc_req_arbiter: directed vector table,
//            hand sequences and randomized transfers against a queue-free
//            round-robin model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdc_req_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 2;
    localparam int TMO   = 10;

    logic                  rst;
    logic                  src_clk;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic                  busy;
    logic [IDXW+WIDTH-1:0] hs_src;
    logic                  hs_val;
    logic                  hs_ack;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    typedef struct {
        logic [NREQ-1:0]       rq;
        logic [NREQ*WIDTH-1:0] dat;
        int                    dly;
        bit                    early;
        int                    exp_idx;
    } vec_t;

    vec_t vecs[6];

    cdc_req_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .TMO   (TMO)
    ) dut (
        .rst      (rst),
        .src_clk  (src_clk),
        .req      (req),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .hs_src   (hs_src),
        .hs_val   (hs_val),
        .hs_ack   (hs_ack)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Winner = first requester at or after the pointer, counting round the ring
    function automatic int model_pick(input logic [NREQ-1:0] rv, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (((rv >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge src_clk);
        rst = 1'b1;
        #1;
        check("reset_outputs", {hs_src, hs_val, done, err, busy}, 64'd0);
        @(negedge src_clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic run_xfer(input logic [NREQ-1:0] rv, input logic [NREQ*WIDTH-1:0] dv,
                            input int dly, input bit early, input bit hold, input bit drop,
                            input int exp_idx);
        int                    idx;
        int                    w;
        bit                    seen;
        logic [WIDTH-1:0]      slice;
        logic [IDXW+WIDTH-1:0] exp_src;
        logic [NREQ-1:0]       onehot;
        req      = rv;
        req_data = dv;
        idx      = (exp_idx >= 0) ? exp_idx : model_pick(rv, m_ptr);
        slice    = WIDTH'(dv >> (idx * WIDTH));
        exp_src  = {IDXW'(idx), slice};
        onehot   = NREQ'(1 << idx);
        seen     = 1'b0;
        w        = 0;
        while (w < 4 && !seen) begin
            @(negedge src_clk);
            w++;
            if (hs_val) seen = 1'b1;
        end
        if (!seen) begin
            check("hs_val_timeout", 64'd0, 64'd1);
            req = '0;
            return;
        end
        check("req_to_val_cycles", 64'(w), 64'd1);
        check("launch_src", 64'(hs_src), 64'(exp_src));
        check("launch_busy", {63'd0, busy}, 64'd1);
        req_data = {$urandom, $urandom};
        if (drop) req = '0;
        if (early) hs_ack = 1'b1;
        for (int c = 0; c < dly; c++) begin
            @(negedge src_clk);
            hs_ack = 1'b0;
            check("wait_src_stable", 64'(hs_src), 64'(exp_src));
            check("wait_flags", 64'({hs_val, busy, done, err}), 64'({1'b0, 1'b1, 8'd0}));
        end
        hs_ack = 1'b1;
        @(negedge src_clk);
        hs_ack = 1'b0;
        check("done_pulse", 64'({done, err, busy, hs_val}), 64'({onehot, 4'd0, 1'b0, 1'b0}));
        m_ptr = (idx + 1) % NREQ;
        if (!hold) begin
            req = '0;
            @(negedge src_clk);
            check("done_single", 64'({done, busy}), 64'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        hs_ack   = 1'b0;
        #1;
        check("async_reset_state", {hs_src, hs_val, done, err, busy}, 64'd0);
        repeat (2) @(negedge src_clk);
        check("reset_held_state", {hs_src, hs_val, done, err, busy}, 64'd0);
        rst = 1'b0;

        vecs[0] = '{rq: 4'b0010, dat: 32'h4433_A511, dly: 6, early: 1'b0, exp_idx: 1};
        vecs[1] = '{rq: 4'b1001, dat: 32'h1234_5678, dly: 2, early: 1'b1, exp_idx: 3};
        vecs[2] = '{rq: 4'b1001, dat: 32'hDEAD_BEEF, dly: 1, early: 1'b0, exp_idx: 0};
        vecs[3] = '{rq: 4'b1001, dat: 32'hCAFE_F00D, dly: 3, early: 1'b0, exp_idx: 3};
        vecs[4] = '{rq: 4'b0110, dat: 32'h0102_0304, dly: 1, early: 1'b1, exp_idx: 1};
        vecs[5] = '{rq: 4'b0100, dat: 32'h55AA_33CC, dly: 4, early: 1'b0, exp_idx: 2};

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].rq, vecs[i].dat, vecs[i].dly, vecs[i].early, 1'b0, 1'b0,
                     vecs[i].exp_idx);
        end

        // All four held continuously from pointer 0
        do_reset();
        begin
            int order[5];
            order = '{0, 1, 2, 3, 0};
            for (int g = 0; g < 5; g++) begin
                run_xfer(4'b1111, {$urandom}, 1 + g, 1'b0, (g < 4), 1'b0, order[g]);
            end
        end

        // Stray ack while idle
        @(negedge src_clk);
        hs_ack = 1'b1;
        @(negedge src_clk);
        hs_ack = 1'b0;
        check("stray_ack_idle", 64'({done, busy, hs_val}), 64'd0);
        @(negedge src_clk);
        check("stray_ack_after", 64'({done, busy}), 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_xfer(NREQ'($urandom_range(1, 15)), {$urandom}, $urandom_range(1, 8),
                     ($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 3) == 0), -1);
        end

        // Reset in the middle of WAIT, then grant must restart from pointer 0
        run_xfer(4'b0001, 32'h0000_0077, 1, 1'b0, 1'b0, 1'b0, -1);
        req      = 4'b0100;
        req_data = 32'h0099_0000;
        begin
            bit seen;
            seen = 1'b0;
            for (int w = 0; w < 4 && !seen; w++) begin
                @(negedge src_clk);
                if (hs_val) seen = 1'b1;
            end
            check("midwait_launch", {63'd0, seen}, 64'd1);
        end
        repeat (2) @(negedge src_clk);
        rst = 1'b1;
        #1;
        check("midwait_reset_outputs", {hs_src, hs_val, done, err, busy}, 64'd0);
        req = '0;
        @(negedge src_clk);
        check("midwait_no_done", 64'({done, err}), 64'd0);
        rst   = 1'b0;
        m_ptr = 0;
        run_xfer(4'b1001, 32'h1100_0022, 2, 1'b0, 1'b0, 1'b0, 0);

`ifdef CDC_ARB_TIMEOUT_EN
        begin
            int              idx;
            logic [NREQ-1:0] onehot;
            bit              seen;
            req      = 4'b0010;
            req_data = 32'h0000_3C00;
            idx      = model_pick(4'b0010, m_ptr);
            onehot   = NREQ'(1 << idx);
            seen     = 1'b0;
            for (int w = 0; w < 4 && !seen; w++) begin
                @(negedge src_clk);
                if (hs_val) seen = 1'b1;
            end
            check("tmo_launch", {63'd0, seen}, 64'd1);
            for (int c = 0; c < TMO; c++) begin
                @(negedge src_clk);
                check("tmo_waiting", 64'({err, busy}), 64'({4'd0, 1'b1}));
            end
            @(negedge src_clk);
            check("tmo_err_pulse", 64'({err, done, busy}), 64'({onehot, 4'd0, 1'b0}));
            req    = '0;
            hs_ack = 1'b1;
            m_ptr  = (idx + 1) % NREQ;
            @(negedge src_clk);
            hs_ack = 1'b0;
            check("tmo_late_ack", 64'({done, err, busy}), 64'd0);
            run_xfer(4'b1111, 32'h5566_7788, 1, 1'b0, 1'b0, 1'b0, -1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
